// File: rtl/acc_rec_pkg.sv
// Shared definitions for the multi-channel accumulate event recorder.
//  - REC_W / field offsets: layout of one record in its natural (unswapped) form
//  - word_swap(): reverses the four 64-bit words of a record so that the
//    downstream 256->64 little-endian readback FIFO emits the index word first
package acc_rec_pkg;

    localparam int REC_W    = 256;
    localparam int CH_ID_W  = 8;
    localparam int WORD_W   = 64;

    // Natural record layout, MSB first:
    // {index[31:0], start[63:0], duration[31:0], end[63:0],
    //  ch_id[7:0], 8'h0, drop_cnt[15:0], 32'h0}
    localparam int IDX_LSB   = 224;
    localparam int IDX_W     = 32;
    localparam int START_LSB = 160;
    localparam int START_W   = 64;
    localparam int DUR_LSB   = 128;
    localparam int DUR_W     = 32;
    localparam int END_LSB   = 64;
    localparam int END_W     = 64;
    localparam int CHID_LSB  = 56;
    localparam int DROP_LSB  = 32;
    localparam int DROP_W    = 16;

    // Word 0 of the natural layout lands in bits 255:192 and so on.
    function automatic logic [REC_W-1:0] word_swap(input logic [REC_W-1:0] rec);
        logic [REC_W-1:0] swapped;
        for (int w = 0; w < REC_W / WORD_W; w++) begin
            swapped[(REC_W/WORD_W-1-w)*WORD_W +: WORD_W] = rec[w*WORD_W +: WORD_W];
        end
        return swapped;
    endfunction

endpackage

// File: rtl/acc_rec_fifo.sv
// Synchronous first-word-fall-through FIFO with a registered output stage.
// A written word goes into the storage array first and is moved into the
// output register on a later edge, so an empty FIFO shows rd_valid_o two
// edges after the write request is presented (write edge, then load edge).
//  clk_i, rst_i          clock, synchronous active-high reset
//  wr_en_i / wr_data_i   write request and data, accepted when wr_ready_o
//  wr_ready_o            room available (also true when full but reading)
//  rd_valid_o/rd_ready_i output handshake; rd_data_o holds while not taken
//  level_o               words held, storage plus output register
module acc_rec_fifo #(
    parameter int DATA_W = 256,
    parameter int DEPTH  = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       wr_en_i,
    input  logic [DATA_W-1:0]          wr_data_i,
    output logic                       wr_ready_o,
    output logic                       rd_valid_o,
    input  logic                       rd_ready_i,
    output logic [DATA_W-1:0]          rd_data_o,
    output logic [$clog2(DEPTH):0]     level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_reg;
    logic [AW-1:0]     rd_ptr_reg;
    logic [AW:0]       mem_cnt_reg;
    logic              out_valid_reg;
    logic [DATA_W-1:0] out_data_reg;

    logic rd_fire;
    logic wr_fire;
    logic load;

    assign rd_fire    = out_valid_reg & rd_ready_i;
    // Refill the output register whenever it is empty or being taken.
    assign load       = (mem_cnt_reg != '0) && (!out_valid_reg || rd_fire);
    assign level_o    = mem_cnt_reg + {{AW{1'b0}}, out_valid_reg};
    assign wr_ready_o = (level_o != (AW+1)'(DEPTH)) || rd_fire;
    assign wr_fire    = wr_en_i & wr_ready_o;

    assign rd_valid_o = out_valid_reg;
    assign rd_data_o  = out_data_reg;

    // Storage array without reset so it maps onto block RAM.
    always_ff @(posedge clk_i) begin
        if (wr_fire) begin
            mem[wr_ptr_reg] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            mem_cnt_reg   <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
        end else begin
            if (wr_fire) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (load) begin
                rd_ptr_reg    <= rd_ptr_reg + 1'b1;
                out_data_reg  <= mem[rd_ptr_reg];
                out_valid_reg <= 1'b1;
            end else if (rd_fire) begin
                out_valid_reg <= 1'b0;
            end
            mem_cnt_reg <= mem_cnt_reg + {{AW{1'b0}}, wr_fire} - {{AW{1'b0}}, load};
        end
    end

endmodule

// File: rtl/acc_multi_event_recorder.sv
// Multi-channel accumulate-flag event recorder.
// Each channel timestamps its flag pulse (start/end encoder, duration) during
// a PMT scan, filters short pulses, and parks the record in a one-deep
// per-channel slot. A fixed-priority arbiter moves slots into a FWFT FIFO that
// is drained over a valid/ready stream.
//  clk_i, rst_i             clock, synchronous active-high reset
//  pmt_scan_en_i            scan window
//  acc_flag_i               per-channel accumulate flags
//  pmt_precise_encode_i     encoder position
//  min_len_i                minimum pulse length; 0 or 1 disables filtering
//  rec_valid_o/rec_ready_i  record stream handshake, rec_data_o record
//  acc_trigger_num_o        records indexed in the last completed scan
//  drop_cnt_o, overflow_o   slot-collision drops (saturating), sticky flag
//  fifo_level_o             FIFO occupancy
module acc_multi_event_recorder
    import acc_rec_pkg::*;
#(
    parameter int CH_NUM     = 4,
    parameter int ENC_W      = 64,
    parameter int CNT_W      = 32,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          pmt_scan_en_i,
    input  logic [CH_NUM-1:0]             acc_flag_i,
    input  logic [ENC_W-1:0]              pmt_precise_encode_i,
    input  logic [CNT_W-1:0]              min_len_i,
    output logic                          rec_valid_o,
    input  logic                          rec_ready_i,
    output logic [REC_W-1:0]              rec_data_o,
    output logic [CNT_W-1:0]              acc_trigger_num_o,
    output logic [15:0]                   drop_cnt_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic                          overflow_o
);

    logic [CH_NUM-1:0] qual;
    logic [CH_NUM-1:0] slot_valid;
    logic [CH_NUM-1:0] grant;
    logic [CH_NUM-1:0] collide;
    logic [REC_W-1:0]  slot_rec [CH_NUM];
    logic [CNT_W-1:0]  idx_asg  [CH_NUM];

    logic              scan_d_reg;
    logic [CNT_W-1:0]  index_reg;
    logic [CNT_W-1:0]  index_next;
    logic [CNT_W-1:0]  trig_num_reg;
    logic [15:0]       drop_cnt_reg;
    logic [16:0]       drop_sum;
    logic [3:0]        n_collide;
    logic              overflow_reg;

    logic              fifo_wr;
    logic              fifo_wr_ready;
    logic [REC_W-1:0]  fifo_din;

    // ------------------------------------------------------------------
    // Per-channel capture: edge detect, duration, start latch, slot.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_ch
        logic              flag_d_reg;
        logic              armed_reg;
        logic [CNT_W-1:0]  dur_reg;
        logic [ENC_W-1:0]  start_reg;
        logic              slot_valid_reg;
        logic [REC_W-1:0]  slot_data_reg;
        logic              pose;
        logic              nege;
        logic              long_enough;
        logic              store;
        logic [REC_W-1:0]  rec_next;

        assign pose        = ~flag_d_reg & acc_flag_i[gi];
        assign nege        = flag_d_reg & ~acc_flag_i[gi];
        assign long_enough = (min_len_i < CNT_W'(2)) || (dur_reg >= min_len_i);
        assign qual[gi]    = nege & armed_reg & pmt_scan_en_i & long_enough;
        assign store       = qual[gi] & ~collide[gi];

        assign rec_next = word_swap({32'(idx_asg[gi]), 64'(start_reg), 32'(dur_reg),
                                     64'(pmt_precise_encode_i), CH_ID_W'(gi), 8'h00,
                                     drop_cnt_reg, 32'h0});

        assign slot_valid[gi] = slot_valid_reg;
        assign slot_rec[gi]   = slot_data_reg;

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                // Treat every flag as already high after reset: a flag that is
                // still high from before the reset must not look like a new
                // rising edge, and a spurious falling edge is harmless because
                // nothing is armed.
                flag_d_reg     <= 1'b1;
                armed_reg      <= 1'b0;
                dur_reg        <= '0;
                start_reg      <= '0;
                slot_valid_reg <= 1'b0;
                slot_data_reg  <= '0;
            end else begin
                flag_d_reg <= acc_flag_i[gi];

                if (acc_flag_i[gi]) begin
                    if (dur_reg != '1) begin
                        dur_reg <= dur_reg + 1'b1;
                    end
                end else begin
                    dur_reg <= '0;
                end

                // Leaving the scan window aborts any pulse in flight.
                if (!pmt_scan_en_i) begin
                    armed_reg <= 1'b0;
                end else if (pose) begin
                    armed_reg <= 1'b1;
                    start_reg <= pmt_precise_encode_i;
                end else if (nege) begin
                    armed_reg <= 1'b0;
                end

                if (store) begin
                    slot_valid_reg <= 1'b1;
                    slot_data_reg  <= rec_next;
                end else if (grant[gi]) begin
                    slot_valid_reg <= 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Index assignment in ascending channel order and collision detection.
    // A slot being drained this edge can take a new record at the same edge.
    // ------------------------------------------------------------------
    always_comb begin
        index_next = index_reg;
        n_collide  = '0;
        collide    = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            if (qual[i]) begin
                index_next = index_next + 1'b1;
            end
            idx_asg[i] = index_next;
            collide[i] = qual[i] & slot_valid[i] & ~grant[i];
            if (collide[i]) begin
                n_collide = n_collide + 4'd1;
            end
        end
        drop_sum = {1'b0, drop_cnt_reg} + 17'(n_collide);
    end

    // Lowest-numbered occupied slot wins the FIFO write port.
    always_comb begin
        grant    = '0;
        fifo_wr  = 1'b0;
        fifo_din = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            if (slot_valid[i] && !fifo_wr && fifo_wr_ready) begin
                grant[i] = 1'b1;
                fifo_wr  = 1'b1;
                fifo_din = slot_rec[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Scan-level totals and drop statistics.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            scan_d_reg   <= 1'b0;
            index_reg    <= '0;
            trig_num_reg <= '0;
            drop_cnt_reg <= '0;
            overflow_reg <= 1'b0;
        end else begin
            scan_d_reg <= pmt_scan_en_i;
            index_reg  <= pmt_scan_en_i ? index_next : '0;
            if (scan_d_reg && !pmt_scan_en_i) begin
                trig_num_reg <= index_reg;
            end
            drop_cnt_reg <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            if (|collide) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    acc_rec_fifo #(
        .DATA_W (REC_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .wr_en_i    (fifo_wr),
        .wr_data_i  (fifo_din),
        .wr_ready_o (fifo_wr_ready),
        .rd_valid_o (rec_valid_o),
        .rd_ready_i (rec_ready_i),
        .rd_data_o  (rec_data_o),
        .level_o    (fifo_level_o)
    );

    assign acc_trigger_num_o = trig_num_reg;
    assign drop_cnt_o        = drop_cnt_reg;
    assign overflow_o        = overflow_reg;

endmodule

// File: tb/tb_acc_multi_event_recorder.sv
module tb_acc_multi_event_recorder;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         scan_en = 1'b0;
    logic [3:0]   flag = '0;
    logic [63:0]  enc = 64'h0;
    logic [31:0]  min_len = '0;
    logic         rec_valid;
    logic         rec_ready = 1'b1;
    logic [255:0] rec_data;
    logic [31:0]  trig_num;
    logic [15:0]  drop_cnt;
    logic [4:0]   fifo_level;
    logic         overflow;

    int total = 0;
    int bad   = 0;
    int next_idx = 0;
    logic [15:0]  exp_drop = 16'h0;
    logic [255:0] exp_q[$];
    logic [255:0] mon_exp;

    always #5 clk = ~clk;

    acc_multi_event_recorder dut (
        .clk_i                (clk),
        .rst_i                (rst),
        .pmt_scan_en_i        (scan_en),
        .acc_flag_i           (flag),
        .pmt_precise_encode_i (enc),
        .min_len_i            (min_len),
        .rec_valid_o          (rec_valid),
        .rec_ready_i          (rec_ready),
        .rec_data_o           (rec_data),
        .acc_trigger_num_o    (trig_num),
        .drop_cnt_o           (drop_cnt),
        .fifo_level_o         (fifo_level),
        .overflow_o           (overflow)
    );

    // Expected record: natural layout, then the four 64-bit words reversed.
    function automatic logic [255:0] build(input logic [31:0] idx, input logic [63:0] st,
                                           input logic [31:0] du, input logic [63:0] en,
                                           input logic [7:0] ch, input logic [15:0] dr);
        logic [255:0] t;
        logic [255:0] r;
        t = {idx, st, du, en, ch, 8'h00, dr, 32'h0};
        r[255:192] = t[63:0];
        r[191:128] = t[127:64];
        r[127:64]  = t[191:128];
        r[63:0]    = t[255:192];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        enc = enc + 64'd1;
    endtask

    // Scoreboard: a transfer happens on the next rising edge; sample it at the
    // falling edge while everything is stable.
    always @(negedge clk) begin
        if (!rst && rec_valid && rec_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_rec got=%h required=none", rec_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (rec_data !== mon_exp) begin
                    bad++;
                    $display("FAIL rec_data got=%h required=%h", rec_data, mon_exp);
                end else begin
                    $display("rec ok idx=%0d ch=%0d data=%h", rec_data[63:32], rec_data[255:248], rec_data);
                end
            end
        end
    end

    // Pulse on every channel of mask for len cycles. consume: the pulse takes
    // an index; push: it is expected to reach the output.
    task automatic pulse(input logic [3:0] mask, input int len, input bit consume, input bit push);
        logic [63:0] st;
        st = enc;
        flag = flag | mask;
        repeat (len) tick();
        for (int c = 0; c < 4; c++) begin
            if (mask[c] && consume) begin
                next_idx++;
                if (push) exp_q.push_back(build(32'(next_idx), st, 32'(len), enc, 8'(c), exp_drop));
            end
        end
        flag = flag & ~mask;
        tick();
        tick();
    endtask

    task automatic scan_start();
        scan_en = 1'b1;
        next_idx = 0;
        tick();
    endtask

    task automatic scan_stop();
        scan_en = 1'b0;
        tick();
        tick();
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || rec_valid) && n < 300) begin
            tick();
            n++;
        end
        total++;
        if (exp_q.size() != 0 || rec_valid) begin
            bad++;
            $display("FAIL %s_drain pending=%0d valid=%0b required=0", name, exp_q.size(), rec_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        total += 6;
        if (rec_valid !== 1'b0)  begin bad++; $display("FAIL reset_valid got=%0b required=0", rec_valid); end
        if (rec_data !== '0)     begin bad++; $display("FAIL reset_data got=%h required=0", rec_data); end
        if (fifo_level !== '0)   begin bad++; $display("FAIL reset_level got=%0d required=0", fifo_level); end
        if (trig_num !== '0)     begin bad++; $display("FAIL reset_trig got=%0d required=0", trig_num); end
        if (drop_cnt !== '0)     begin bad++; $display("FAIL reset_drop got=%0d required=0", drop_cnt); end
        if (overflow !== 1'b0)   begin bad++; $display("FAIL reset_ovf got=%0b required=0", overflow); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        logic [63:0] st;
        min_len = 0;
        rec_ready = 1'b1;
        scan_start();
        enc = 64'h100;
        st = enc;
        flag[0] = 1'b1;
        repeat (10) tick();
        next_idx++;
        exp_q.push_back(build(32'(next_idx), st, 32'd10, enc, 8'd0, exp_drop));
        flag[0] = 1'b0;
        tick();                                  // slot load edge
        tick();                                  // FIFO write edge
        total += 3;
        if (rec_valid !== 1'b0) begin bad++; $display("FAIL single_valid_e1 got=%0b required=0", rec_valid); end
        if (fifo_level !== 5'd1) begin bad++; $display("FAIL single_level_e1 got=%0d required=1", fifo_level); end
        tick();                                  // output register load edge
        if (rec_valid !== 1'b1) begin bad++; $display("FAIL single_valid_e2 got=%0b required=1", rec_valid); end
        wait_drain("single");
        scan_stop();
    endtask

    task automatic test_simultaneous();
        scan_start();
        pulse(4'b0001, 3, 1, 1);
        pulse(4'b1010, 4, 1, 1);
        wait_drain("simul");
        total++;
        if (drop_cnt !== 16'd0) begin bad++; $display("FAIL simul_drop got=%0d required=0", drop_cnt); end
        scan_stop();
        total++;
        if (trig_num !== 32'd3) begin bad++; $display("FAIL simul_trig got=%0d required=3", trig_num); end
    endtask

    task automatic test_min_len();
        min_len = 5;
        scan_start();
        pulse(4'b0001, 4, 0, 0);
        pulse(4'b0001, 5, 1, 1);
        wait_drain("minlen");
        scan_stop();
        total++;
        if (trig_num !== 32'd1) begin bad++; $display("FAIL minlen_trig got=%0d required=1", trig_num); end
        min_len = 0;
    endtask

    task automatic test_abort();
        scan_start();
        pulse(4'b0001, 3, 1, 1);
        pulse(4'b0010, 3, 1, 1);
        flag[2] = 1'b1;
        repeat (3) tick();
        scan_stop();
        total++;
        if (trig_num !== 32'd2) begin bad++; $display("FAIL abort_trig got=%0d required=2", trig_num); end
        flag[2] = 1'b0;
        repeat (3) tick();
        scan_start();
        pulse(4'b0001, 3, 1, 1);
        total++;
        if (trig_num !== 32'd2) begin bad++; $display("FAIL abort_trig_hold got=%0d required=2", trig_num); end
        scan_stop();
        total++;
        if (trig_num !== 32'd1) begin bad++; $display("FAIL abort_trig2 got=%0d required=1", trig_num); end
        wait_drain("abort");
    endtask

    task automatic test_overflow();
        rec_ready = 1'b0;
        scan_start();
        for (int p = 1; p <= 20; p++) begin
            pulse(4'b0001, 2, 1, p <= 17);
        end
        repeat (3) tick();
        total += 4;
        if (fifo_level !== 5'd16) begin bad++; $display("FAIL ovf_level got=%0d required=16", fifo_level); end
        if (drop_cnt !== 16'd3)   begin bad++; $display("FAIL ovf_drop got=%0d required=3", drop_cnt); end
        if (overflow !== 1'b1)    begin bad++; $display("FAIL ovf_flag got=%0b required=1", overflow); end
        if (rec_data !== exp_q[0]) begin bad++; $display("FAIL ovf_hold got=%h required=%h", rec_data, exp_q[0]); end
        rec_ready = 1'b1;
        wait_drain("ovf");
        scan_stop();
        total++;
        if (trig_num !== 32'd20) begin bad++; $display("FAIL ovf_trig got=%0d required=20", trig_num); end
        exp_drop = 16'd3;
    endtask

    task automatic test_reset_mid();
        rec_ready = 1'b0;
        scan_start();
        for (int p = 0; p < 3; p++) pulse(4'b0001, 2, 1, 0);
        flag[0] = 1'b1;
        repeat (2) tick();
        total++;
        if (fifo_level !== 5'd3) begin bad++; $display("FAIL rstmid_pre_level got=%0d required=3", fifo_level); end
        rst = 1'b1;
        tick();
        total += 5;
        if (rec_valid !== 1'b0)  begin bad++; $display("FAIL rstmid_valid got=%0b required=0", rec_valid); end
        if (fifo_level !== '0)   begin bad++; $display("FAIL rstmid_level got=%0d required=0", fifo_level); end
        if (trig_num !== '0)     begin bad++; $display("FAIL rstmid_trig got=%0d required=0", trig_num); end
        if (drop_cnt !== '0)     begin bad++; $display("FAIL rstmid_drop got=%0d required=0", drop_cnt); end
        if (overflow !== 1'b0)   begin bad++; $display("FAIL rstmid_ovf got=%0b required=0", overflow); end
        rst = 1'b0;
        repeat (3) tick();
        flag[0] = 1'b0;
        repeat (4) tick();
        rec_ready = 1'b1;
        repeat (4) tick();
        total += 2;
        if (rec_valid !== 1'b0) begin bad++; $display("FAIL rstmid_norec got=%0b required=0", rec_valid); end
        if (fifo_level !== '0)  begin bad++; $display("FAIL rstmid_level2 got=%0d required=0", fifo_level); end
        scan_stop();
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_min_len();
        test_abort();
        test_overflow();
        test_reset_mid();
        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
